// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signals of the AHB arbiter: master requests in, registered grant/ownership out.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MW-1:0]          HMASTER;
  logic                   HMASTLOCK;
  logic [MW-1:0]          HMASTER_D;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK, HMASTER_D
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK, HMASTER_D
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter: re-arbitrates only at burst ends with no lock held,
// and pipelines ownership into address-phase (HMASTER) and data-phase (HMASTER_D) indices.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  ahb_bus_arbiter_if.slave bus
);
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [MW-1:0]          DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [MW-1:0]          RR_RST  = (DEFAULT_MASTER == NUM_MASTERS-1) ? '0 : MW'(DEFAULT_MASTER + 1);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [MW-1:0]          gnt_idx;
  logic [MW-1:0]          rr_ptr;
  logic [3:0]             beats_left;
  logic [3:0]             beats_nxt;
  logic [MW-1:0]          winner;
  logic [MW-1:0]          cand;
  logic                   found;
  logic                   arb_ok;
  logic [NUM_MASTERS-1:0] gnt_nxt;

  function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] v);
    return (v == MW'(NUM_MASTERS-1)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [3:0] burst_len_m1(input logic [2:0] hb);
    case (hb[2:1])
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      2'b11:   return 4'd15;
      default: return 4'd0;  // SINGLE and INCR carry no fixed length
    endcase
  endfunction

  always_comb begin
    beats_nxt = beats_left;
    case (bus.HTRANS)
      T_NONSEQ: beats_nxt = burst_len_m1(bus.HBURST);
      T_SEQ:    beats_nxt = (beats_left == 4'd0) ? 4'd0 : beats_left - 4'd1;
      T_BUSY:   beats_nxt = beats_left;
      T_IDLE:   beats_nxt = 4'd0;
      default:  beats_nxt = 4'd0;
    endcase
  end

  assign arb_ok = bus.HREADY && (beats_nxt == 4'd0) && !bus.HLOCK[gnt_idx];

  // Rotating scan starting at rr_ptr; an empty request vector parks on the default master.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!found && bus.HBUSREQ[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
      cand = wrap_inc(cand);
    end
  end

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_gnt
    assign gnt_nxt[i] = (winner == MW'(i));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      bus.HGRANT    <= DEF_GNT;
      gnt_idx       <= DEF_IDX;
      rr_ptr        <= RR_RST;
      beats_left    <= 4'd0;
      bus.HMASTER   <= DEF_IDX;
      bus.HMASTLOCK <= 1'b0;
      bus.HMASTER_D <= DEF_IDX;
    end else if (bus.HREADY) begin
      beats_left <= beats_nxt;
      if (arb_ok) begin
        bus.HGRANT <= gnt_nxt;
        gnt_idx    <= winner;
        rr_ptr     <= wrap_inc(winner);
      end
      // Ownership follows the grant held before this edge, one HREADY cycle per stage.
      bus.HMASTER   <= gnt_idx;
      bus.HMASTLOCK <= bus.HLOCK[gnt_idx];
      bus.HMASTER_D <= bus.HMASTER;
    end
  end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: reset, rotation, fixed bursts, wait states, locks, async reset.
module tb_ahb_bus_arbiter;
  localparam int N  = 4;
  localparam int MW = 2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   checks   = 0;
  int   failures = 0;
  int   exp_order [5] = '{1, 2, 3, 0, 1};

  ahb_bus_arbiter_if #(.NUM_MASTERS(N), .MW(MW)) bus ();

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MW(MW), .DEFAULT_MASTER(0)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_reset();
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = IDLE;
    bus.HBURST  = SINGLE;
    bus.HREADY  = 1'b1;
    tick();
    chk("rst_gnt",   32'(bus.HGRANT),    32'b0001);
    chk("rst_hm",    32'(bus.HMASTER),   0);
    chk("rst_hmd",   32'(bus.HMASTER_D), 0);
    chk("rst_mlock", 32'(bus.HMASTLOCK), 0);
    HRESETn = 1'b1;

    // single request: grant, then HMASTER, then HMASTER_D
    bus.HBUSREQ = 4'b0100;
    tick();
    chk("t1_gnt",    32'(bus.HGRANT),    32'b0100);
    chk("t1_hm_lag", 32'(bus.HMASTER),   0);
    tick();
    chk("t1_hm",     32'(bus.HMASTER),   2);
    chk("t1_hmd_lag",32'(bus.HMASTER_D), 0);
    tick();
    chk("t1_hmd",    32'(bus.HMASTER_D), 2);
    bus.HBUSREQ = 4'b0000;
    tick();
    chk("t1_park",   32'(bus.HGRANT),    32'b0001);

    // all request, single transfers: rotation from rr_ptr=1
    pulse_reset();
    bus.HBUSREQ = 4'b1111;
    bus.HTRANS  = NONSEQ;
    bus.HBURST  = SINGLE;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_gnt", 32'(bus.HGRANT), 32'(1) << exp_order[i]);
    end
    chk("t2_hm", 32'(bus.HMASTER), 0);

    // INCR4 owned by M1, M3 requests on beat 1
    pulse_reset();
    bus.HBUSREQ = 4'b0010;
    bus.HTRANS  = IDLE;
    tick();
    tick();
    chk("t3_own", 32'(bus.HMASTER), 1);
    bus.HBUSREQ = 4'b1010;
    bus.HTRANS  = NONSEQ;
    bus.HBURST  = INCR4;
    tick();
    chk("t3_b1", 32'(bus.HGRANT), 32'b0010);
    bus.HTRANS = SEQ;
    tick();
    chk("t3_b2", 32'(bus.HGRANT), 32'b0010);
    tick();
    chk("t3_b3", 32'(bus.HGRANT), 32'b0010);
    tick();
    chk("t3_b4", 32'(bus.HGRANT), 32'b1000);
    bus.HTRANS = IDLE;
    bus.HREADY = 1'b0;
    tick();
    chk("t3_hm_wait", 32'(bus.HMASTER), 1);
    bus.HREADY = 1'b1;
    tick();
    chk("t3_hm",  32'(bus.HMASTER),   3);
    chk("t3_hmd", 32'(bus.HMASTER_D), 1);

    // same burst with two wait states on beat 2
    pulse_reset();
    bus.HBUSREQ = 4'b0010;
    bus.HTRANS  = IDLE;
    tick();
    tick();
    bus.HBUSREQ = 4'b1010;
    bus.HTRANS  = NONSEQ;
    bus.HBURST  = INCR4;
    tick();
    bus.HTRANS = SEQ;
    bus.HREADY = 1'b0;
    tick();
    chk("t4_w1", 32'(bus.HGRANT), 32'b0010);
    tick();
    chk("t4_w2",    32'(bus.HGRANT),  32'b0010);
    chk("t4_hm_w",  32'(bus.HMASTER), 1);
    bus.HREADY = 1'b1;
    tick();
    chk("t4_b2", 32'(bus.HGRANT), 32'b0010);
    tick();
    chk("t4_b3", 32'(bus.HGRANT), 32'b0010);
    tick();
    chk("t4_b4", 32'(bus.HGRANT), 32'b1000);

    // locked sequence by M0 while M2 requests
    pulse_reset();
    bus.HBUSREQ = 4'b0101;
    bus.HLOCK   = 4'b0001;
    bus.HTRANS  = NONSEQ;
    bus.HBURST  = SINGLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_gnt",  32'(bus.HGRANT),    32'b0001);
      chk("t5_lock", 32'(bus.HMASTLOCK), 1);
    end
    bus.HTRANS = IDLE;
    tick();
    chk("t5_idle_gnt", 32'(bus.HGRANT), 32'b0001);
    bus.HLOCK  = 4'b0000;
    bus.HTRANS = NONSEQ;
    tick();
    chk("t5_rel",   32'(bus.HGRANT),    32'b0100);
    chk("t5_unlock",32'(bus.HMASTLOCK), 0);
    // INCR may be re-arbitrated on its first beat
    bus.HBUSREQ = 4'b0110;
    bus.HBURST  = INCR;
    tick();
    chk("t5_incr", 32'(bus.HGRANT), 32'b0010);

    // async reset in the middle of an INCR8 owned by M2
    pulse_reset();
    bus.HBUSREQ = 4'b0100;
    bus.HTRANS  = IDLE;
    bus.HBURST  = SINGLE;
    tick();
    tick();
    bus.HBUSREQ = 4'b0101;
    bus.HTRANS  = NONSEQ;
    bus.HBURST  = INCR8;
    tick();
    chk("t6_b1", 32'(bus.HGRANT), 32'b0100);
    bus.HTRANS = SEQ;
    tick();
    chk("t6_b2", 32'(bus.HGRANT),  32'b0100);
    chk("t6_hm", 32'(bus.HMASTER), 2);
    HRESETn = 1'b0;
    #2;
    chk("t6_rst_gnt",   32'(bus.HGRANT),    32'b0001);
    chk("t6_rst_hm",    32'(bus.HMASTER),   0);
    chk("t6_rst_hmd",   32'(bus.HMASTER_D), 0);
    chk("t6_rst_mlock", 32'(bus.HMASTLOCK), 0);
    HRESETn = 1'b1;
    tick();
    chk("t6_rewin", 32'(bus.HGRANT), 32'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
